// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher.
package led_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  // Timer width: just wide enough to hold the longer of the two phase lengths.
  function automatic int timer_width(input int on_cycles, input int off_cycles);
    int longest;
    longest = (on_cycles > off_cycles) ? on_cycles : off_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable phase counter: counts 0 .. phase_len-1 and strobes done on the last count.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] phase_len,
  output logic         done
);

  logic [W-1:0] count;

  assign done = (count == (phase_len - W'(1)));

  // Free-running phase count, restarted at zero whenever the owner clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event pulses into human-visible LED blinks, queueing
// events that arrive mid-blink. Optional feature macro: LED_STRETCH_OVERFLOW_EN
// (defined: sticky overflow flag; undefined: overflow tied to 0).
module led_pulse_stretcher
  import led_stretch_pkg::*;
#(
  parameter int ON_CYCLES     = 25000000,
  parameter int OFF_CYCLES    = 25000000,
  parameter int PENDING_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse,
  output logic led,
  output logic busy,
  output logic overflow
);

  localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LEN  = TW'(ON_CYCLES);
  localparam logic [TW-1:0] OFF_LEN = TW'(OFF_CYCLES);
  localparam logic [PENDING_WIDTH-1:0] PEND_MAX = '1;

  state_t                   state;
  state_t                   state_next;
  logic [PENDING_WIDTH-1:0] pending;
  logic [PENDING_WIDTH-1:0] pending_next;
  logic [TW-1:0]            phase_len;
  logic                     phase_end;
  logic                     timer_clear;
  logic                     off_end;
  logic                     consume;
  logic                     inc;

  assign phase_len   = (state == OFF) ? OFF_LEN : ON_LEN;
  assign timer_clear = (state == IDLE) || phase_end;

  cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (timer_clear),
    .phase_len (phase_len),
    .done      (phase_end)
  );

  // A pulse landing on the last OFF cycle with nothing queued starts the next
  // blink directly instead of passing through the pending counter.
  assign off_end = (state == OFF) && phase_end;
  assign consume = off_end && (pending != '0);
  assign inc     = (state != IDLE) && pulse && !(off_end && (pending == '0));

  // Next-state decode for the blink sequencer.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pulse) state_next = ON;
      end
      ON: begin
        if (phase_end) state_next = OFF;
      end
      OFF: begin
        if (phase_end) state_next = ((pending != '0) || pulse) ? ON : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending-blink bookkeeping; an increment at full scale is dropped.
  always_comb begin
    pending_next = pending;
    if (inc && !consume) begin
      if (pending != PEND_MAX) pending_next = pending + 1'b1;
    end else if (consume && !inc) begin
      pending_next = pending - 1'b1;
    end
  end

  // State, queue and registered LED drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      led     <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      led     <= (state_next == ON);
    end
  end

  assign busy = (state != IDLE) || (pending != '0);

`ifdef LED_STRETCH_OVERFLOW_EN
  logic drop;
  logic overflow_q;

  assign drop = inc && !consume && (pending == PEND_MAX);

  // Sticky record that at least one event was lost; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Converts single-cycle event pulses from clock-domain logic into human-visible LED blinks. Each accepted pulse produces exactly one blink of fixed on-time, followed by a fixed dark gap. Pulses that arrive during a blink are counted and replayed as further blinks, so N events give N distinct blinks. It is the output-side counterpart of the button debouncer: clock-speed events out to human speed, rather than human input in to clock-speed events.

## Interface
- `ON_CYCLES`, default 25000000, LED high time per blink in clk cycles, must be >= 1
- `OFF_CYCLES`, default 25000000, minimum LED low gap after each blink in clk cycles, must be >= 1
- `PENDING_WIDTH`, default 4, width of the pending-blink counter; max queued = 2^PENDING_WIDTH-1
- `clk` input 1: single clock; all logic is rising-edge
- `rst` input 1: asynchronous, active-high reset
- `pulse` input 1: event request, sampled each rising edge; a high level for k cycles counts as k events
- `led` output 1: registered LED drive
- `busy` output 1: high while state != IDLE or pending != 0
- `overflow` output 1: sticky flag, set when an event is dropped

## Operation
- States: IDLE, ON, OFF.
- The timer counts 0 .. `PHASE_LEN`-1 within the current phase, where `PHASE_LEN` is `ON_CYCLES` in ON and `OFF_CYCLES` in OFF.
- The timer is `$clog2(max(ON_CYCLES,OFF_CYCLES)+1)` bits wide.
- IDLE:
  - `pulse` -> ON, timer=0, `led`=1.
  - `pending` is unchanged and is always 0 in IDLE.
- ON:
  - At timer == `ON_CYCLES`-1 -> OFF, timer=0, `led`=0.
- OFF:
  - At timer == `OFF_CYCLES`-1, if `pending`>0 or `pulse` -> ON, timer=0, `led`=1.
  - Otherwise -> IDLE.
- Pending accounting, every cycle outside IDLE:
  - consume = (OFF end && `pending`>0).
  - inc = `pulse` && !(OFF end && `pending`==0). A pulse at OFF end with `pending`==0 starts the next blink directly.
  - inc && consume -> `pending` unchanged.
  - inc only -> `pending`+1.
  - consume only -> `pending`-1.
- Saturation: inc at `pending`==max without consume -> event dropped, `pending` stays max, `overflow` set.
- `overflow` clears only on `rst`.
- Reset (any time, including mid-blink):
  - state IDLE, timer 0, `pending` 0.
  - `led` 0, `busy` 0, `overflow` 0.
  - No blink resumes after reset release.

## Timing
- Latency: `pulse` high in cycle n while IDLE -> `led` high cycles n+1 .. n+`ON_CYCLES`.
- `led` is low for at least `OFF_CYCLES` cycles between blinks.
- Back-to-back blinks rise `ON_CYCLES`+`OFF_CYCLES` cycles apart.
- `busy` is a registered-state decode with no extra latency; it goes low the cycle after the final OFF phase ends with no further work.
- `overflow` rises the cycle after the dropped pulse.
- `pulse` must be synchronous to `clk`; no internal synchronizer.

## Configuration
- `LED_STRETCH_OVERFLOW_EN` defined: `overflow` is the sticky flag described above.
- `LED_STRETCH_OVERFLOW_EN` undefined:
  - The flag register is removed and `overflow` is tied to 0.
  - Saturation/drop behaviour is unchanged.

## Structure
- Package `led_stretch_pkg`:
  - state enum typedef (IDLE, ON, OFF)
  - helper function for timer width
- One sub-module is natural: `cycle_timer`.
  - Loadable phase counter.
  - Inputs: clear, phase length.
  - Output: terminal-count strobe.
- The FSM and pending counter live in `led_pulse_stretcher`.

## Test plan
All scenarios use `ON_CYCLES`=4, `OFF_CYCLES`=3, `PENDING_WIDTH`=2 (max pending 3).
- **Single pulse:** `pulse` at cycle 10 -> `led` high 11-14, low 15 onward; `busy` high 11-17, low at 18.
- **Three consecutive pulses:** `pulse` at cycles 10, 11, 12 -> blinks rise at 11, 18, 25, each 4 cycles high; `busy` low at 32.
- **Pulse on final OFF cycle:** single blink from cycle 10, second `pulse` at cycle 17 (last OFF cycle, `pending`=0) -> `led` rises at 18.
- **Overflow:** `pulse` held high cycles 10-14 -> four blinks total (rising 11, 18, 25, 32).
  - With macro: `overflow` high from cycle 15.
  - Without macro: `overflow` stays 0.
- **Reset mid-blink:** `rst` asserted at cycle 12 mid-blink with `pending`=2 -> `led`, `busy` and `overflow` drop to 0 asynchronously; no blinks after `rst` release without new pulses.
